seg_7_capture: RTL and testbench

SEG_7_CAPTURE -- requirements
Module: seg_7_capture

---
 rtl/seg_7_capture.sv | 154 +++++++++++++++
 tb/tb_seg_7_capture.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_7_capture.sv
// Recovers a 4-digit BCD frame from multiplexed 7-segment lines by qualifying stable digit samples.
// Latency: a digit is captured on its STABLE_CYC-th identical sample; a frame is presented one edge after its last capture.
// Backpressure: out_ready only drains the output register; captures never stall, and an unaccepted frame is overwritten with an overrun pulse.
module seg_7_capture #(
    parameter int STABLE_CYC = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [0:6]  seg_7,
    input  logic [3:0]  dig_en,
    input  logic        out_ready,
    output logic [15:0] bcd,
    output logic [3:0]  dig_err,
    output logic        out_valid,
    output logic        overrun
);

    typedef enum logic [1:0] {SEARCH, COUNT, LOCKED} state_t;

    state_t      state;
    logic [3:0]  count;
    logic [10:0] cand;
    logic [3:0]  mask;
    logic [15:0] dig_reg;
    logic [3:0]  err_reg;
    logic        load;

    logic [10:0] sample;
    logic        qual;
    logic        same;
    logic        capture;
    logic [3:0]  dec_code;
    logic        dec_err;

    // Sample qualification: exactly one digit enable active.
    always_comb begin
        sample  = {dig_en, seg_7};
        qual    = (dig_en != 4'b0000) && ((dig_en & (dig_en - 4'd1)) == 4'b0000);
        same    = (sample == cand);
        capture = (state == COUNT) && qual && same && (count == 4'(STABLE_CYC - 1));
    end

    // Segment pattern to BCD decode; dash and unknown patterns are flagged.
    always_comb begin
        dec_code = 4'hF;
        dec_err  = 1'b1;
        case (seg_7)
            7'b1111110: begin dec_code = 4'd0; dec_err = 1'b0; end
            7'b0110000: begin dec_code = 4'd1; dec_err = 1'b0; end
            7'b1101101: begin dec_code = 4'd2; dec_err = 1'b0; end
            7'b1111001: begin dec_code = 4'd3; dec_err = 1'b0; end
            7'b0110011: begin dec_code = 4'd4; dec_err = 1'b0; end
            7'b1011011: begin dec_code = 4'd5; dec_err = 1'b0; end
            7'b1011111: begin dec_code = 4'd6; dec_err = 1'b0; end
            7'b1110000: begin dec_code = 4'd7; dec_err = 1'b0; end
            7'b1111111: begin dec_code = 4'd8; dec_err = 1'b0; end
            7'b1111011: begin dec_code = 4'd9; dec_err = 1'b0; end
            7'b0000001: begin dec_code = 4'hE; dec_err = 1'b1; end
            default:    begin dec_code = 4'hF; dec_err = 1'b1; end
        endcase
    end

    // Qualifier FSM: tracks the current run of identical qualifying samples.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= SEARCH;
            count <= 4'd0;
            cand  <= 11'd0;
        end else begin
            case (state)
                SEARCH: begin
                    if (qual) begin
                        cand  <= sample;
                        count <= 4'd1;
                        state <= COUNT;
                    end
                end
                COUNT: begin
                    if (!qual) begin
                        count <= 4'd0;
                        state <= SEARCH;
                    end else if (same) begin
                        count <= count + 4'd1;
                        if (count == 4'(STABLE_CYC - 1)) state <= LOCKED;
                    end else begin
                        cand  <= sample;
                        count <= 4'd1;
                    end
                end
                LOCKED: begin
                    if (!qual) begin
                        count <= 4'd0;
                        state <= SEARCH;
                    end else if (!same) begin
                        cand  <= sample;
                        count <= 4'd1;
                        state <= COUNT;
                    end
                end
                default: begin
                    count <= 4'd0;
                    state <= SEARCH;
                end
            endcase
        end
    end

    // Digit capture and frame assembly; a full mask triggers an output load next edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dig_reg <= 16'h0000;
            err_reg <= 4'b0000;
            mask    <= 4'b0000;
            load    <= 1'b0;
        end else begin
            load <= 1'b0;
            if (capture) begin
                for (int i = 0; i < 4; i++) begin
                    if (dig_en[i]) begin
                        dig_reg[4*i +: 4] <= dec_code;
                        err_reg[i]        <= dec_err;
                    end
                end
                if ((mask | dig_en) == 4'b1111) begin
                    mask <= 4'b0000;
                    load <= 1'b1;
                end else begin
                    mask <= mask | dig_en;
                end
            end
        end
    end

    // Output frame register with valid/ready handshake and overrun detection.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bcd       <= 16'h0000;
            dig_err   <= 4'b0000;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (load) begin
                bcd       <= dig_reg;
                dig_err   <= err_reg;
                out_valid <= 1'b1;
                overrun   <= out_valid && !out_ready;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_seg_7_capture.sv
// Bench for seg_7_capture: directed scenarios plus random multiplexed traffic.
// Every cycle is compared against a run-length reference model of the capture rules.
// Outputs are sampled 1 time unit after each rising edge.
module tb_seg_7_capture;

    localparam int STABLE = 4;

    logic        clk;
    logic        rst_n;
    logic [0:6]  seg_7;
    logic [3:0]  dig_en;
    logic        out_ready;
    logic [15:0] bcd;
    logic [3:0]  dig_err;
    logic        out_valid;
    logic        overrun;

    seg_7_capture #(.STABLE_CYC(STABLE)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .seg_7     (seg_7),
        .dig_en    (dig_en),
        .out_ready (out_ready),
        .bcd       (bcd),
        .dig_err   (dig_err),
        .out_valid (out_valid),
        .overrun   (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int ovr_cnt = 0;

    logic [6:0] pat [0:9];
    logic [6:0] dash;

    // reference model state
    logic [10:0] m_prev;
    int          m_run;
    logic [3:0]  m_dig [4];
    logic        m_err [4];
    logic [3:0]  m_mask;
    logic        m_pend;
    logic [15:0] m_bcd;
    logic [3:0]  m_derr;
    logic        m_val;
    logic        m_ovr;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic decode(input logic [6:0] s, output logic [3:0] code, output logic err);
        code = 4'hF;
        err  = 1'b1;
        if (s == dash) code = 4'hE;
        for (int d = 0; d < 10; d++) begin
            if (pat[d] == s) begin
                code = 4'(d);
                err  = 1'b0;
            end
        end
    endtask

    task automatic model_reset();
        m_prev = '0;
        m_run  = 0;
        for (int i = 0; i < 4; i++) begin
            m_dig[i] = 4'h0;
            m_err[i] = 1'b0;
        end
        m_mask = 4'h0;
        m_pend = 1'b0;
        m_bcd  = 16'h0;
        m_derr = 4'h0;
        m_val  = 1'b0;
        m_ovr  = 1'b0;
    endtask

    task automatic model_edge(input logic [3:0] en, input logic [6:0] s, input logic rdy);
        int idx;
        logic [3:0] code;
        logic err;
        if (m_pend) begin
            m_ovr  = m_val && !rdy;
            m_val  = 1'b1;
            m_bcd  = {m_dig[3], m_dig[2], m_dig[1], m_dig[0]};
            m_derr = {m_err[3], m_err[2], m_err[1], m_err[0]};
        end else begin
            m_ovr = 1'b0;
            if (m_val && rdy) m_val = 1'b0;
        end
        m_pend = 1'b0;
        if ($countones(en) != 1) begin
            m_run = 0;
        end else begin
            if ({en, s} == m_prev && m_run > 0) m_run++;
            else m_run = 1;
            m_prev = {en, s};
            if (m_run == STABLE) begin
                idx = 0;
                for (int i = 0; i < 4; i++) if (en[i]) idx = i;
                decode(s, code, err);
                m_dig[idx]  = code;
                m_err[idx]  = err;
                m_mask[idx] = 1'b1;
                if (m_mask == 4'hF) begin
                    m_pend = 1'b1;
                    m_mask = 4'h0;
                end
            end
        end
    endtask

    task automatic step(input logic [3:0] en, input logic [6:0] s, input logic rdy, input logic rn);
        dig_en    = en;
        seg_7     = s;
        out_ready = rdy;
        rst_n     = rn;
        @(posedge clk);
        #1;
        if (!rn) model_reset();
        else model_edge(en, s, rdy);
        if (overrun) ovr_cnt++;
        check("bcd", 32'(bcd), 32'(m_bcd));
        check("dig_err", 32'(dig_err), 32'(m_derr));
        check("out_valid", 32'(out_valid), 32'(m_val));
        check("overrun", 32'(overrun), 32'(m_ovr));
    endtask

    task automatic show(input logic [3:0] en, input logic [6:0] s, input int n, input logic rdy);
        for (int k = 0; k < n; k++) step(en, s, rdy, 1'b1);
    endtask

    task automatic frame(input int a, input int b, input int c, input int d, input logic rdy);
        show(4'b0001, pat[a], 5, rdy);
        show(4'b0010, pat[b], 5, rdy);
        show(4'b0100, pat[c], 5, rdy);
        show(4'b1000, pat[d], 5, rdy);
    endtask

    initial begin
        pat[0] = 7'b1111110; pat[1] = 7'b0110000; pat[2] = 7'b1101101;
        pat[3] = 7'b1111001; pat[4] = 7'b0110011; pat[5] = 7'b1011011;
        pat[6] = 7'b1011111; pat[7] = 7'b1110000; pat[8] = 7'b1111111;
        pat[9] = 7'b1111011;
        dash   = 7'b0000001;
        model_reset();
        dig_en = 4'h0; seg_7 = 7'h0; out_ready = 1'b0; rst_n = 1'b0;

        // reset state
        step(4'h0, 7'h0, 1'b0, 1'b0);
        step(4'h0, 7'h0, 1'b0, 1'b0);
        check("rst_bcd", 32'(bcd), 32'h0);
        check("rst_valid", 32'(out_valid), 32'h0);

        // digits 1,2,3,4 for 6 cycles each, held without ready
        show(4'b0001, pat[1], 6, 1'b0);
        show(4'b0010, pat[2], 6, 1'b0);
        show(4'b0100, pat[3], 6, 1'b0);
        show(4'b1000, pat[4], 3, 1'b0);
        check("no_valid_before_4th", 32'(out_valid), 32'h0);
        show(4'b1000, pat[4], 1, 1'b0);
        check("no_valid_on_capture", 32'(out_valid), 32'h0);
        show(4'b1000, pat[4], 1, 1'b0);
        check("valid_after_frame", 32'(out_valid), 32'h1);
        check("frame_4321", 32'(bcd), 32'h4321);
        check("frame_err", 32'(dig_err), 32'h0);
        show(4'b1000, pat[4], 3, 1'b0);
        check("held_bcd", 32'(bcd), 32'h4321);
        step(4'h0, 7'h0, 1'b1, 1'b1);
        check("accepted", 32'(out_valid), 32'h0);

        // digit 0 shows 7 briefly, then 8; dash on digit 2, lone d on digit 1
        show(4'b0001, pat[7], 3, 1'b0);
        show(4'b0001, pat[8], 5, 1'b0);
        show(4'b0010, 7'b0001000, 5, 1'b0);
        show(4'b0100, dash, 5, 1'b0);
        show(4'b1000, pat[5], 5, 1'b0);
        check("digit0_is_8", 32'(bcd[3:0]), 32'h8);
        check("dash_E", 32'(bcd[11:8]), 32'hE);
        check("bad_F", 32'(bcd[7:4]), 32'hF);
        check("err_0110", 32'(dig_err), 32'h6);
        step(4'h0, 7'h0, 1'b1, 1'b1);

        // multi-hot enables never qualify
        show(4'b0011, pat[1], 10, 1'b0);
        check("multihot_no_valid", 32'(out_valid), 32'h0);

        // back-to-back frames: overrun, then load coinciding with accept
        ovr_cnt = 0;
        frame(1, 2, 3, 4, 1'b0);
        frame(5, 6, 7, 8, 1'b0);
        show(4'b0001, pat[0], 2, 1'b0);
        check("overrun_once", 32'(ovr_cnt), 32'h1);
        check("second_frame", 32'(bcd), 32'h8765);
        ovr_cnt = 0;
        show(4'b0001, pat[9], 5, 1'b0);
        show(4'b0010, pat[9], 5, 1'b0);
        show(4'b0100, pat[9], 5, 1'b0);
        show(4'b1000, pat[9], 4, 1'b0);
        show(4'b1000, pat[9], 1, 1'b1);
        check("load_accept_valid", 32'(out_valid), 32'h1);
        check("load_accept_no_ovr", 32'(ovr_cnt), 32'h0);
        check("load_accept_bcd", 32'(bcd), 32'h9999);

        // reset mid-frame discards partial digits
        step(4'h0, 7'h0, 1'b0, 1'b0);
        check("rst_mid_valid", 32'(out_valid), 32'h0);
        show(4'b0001, pat[1], 5, 1'b0);
        show(4'b0010, pat[2], 5, 1'b0);
        show(4'b0100, pat[3], 5, 1'b0);
        step(4'h0, 7'h0, 1'b0, 1'b0);
        check("rst_mid_bcd", 32'(bcd), 32'h0);
        show(4'b1000, pat[4], 6, 1'b0);
        check("lone_digit_no_valid", 32'(out_valid), 32'h0);

        // randomized multiplexed traffic
        for (int g = 0; g < 600; g++) begin
            logic [3:0] en;
            logic [6:0] s;
            int r;
            int hold;
            r = $urandom_range(0, 9);
            if (r < 8) en = 4'(1 << (r % 4));
            else if (r == 8) en = 4'h0;
            else en = 4'b0011 << $urandom_range(0, 2);
            r = $urandom_range(0, 9);
            if (r < 8) s = pat[$urandom_range(0, 9)];
            else if (r == 8) s = dash;
            else s = 7'($urandom);
            hold = $urandom_range(1, 7);
            if ($urandom_range(0, 99) == 0) step(en, s, 1'b0, 1'b0);
            for (int k = 0; k < hold; k++) step(en, s, 1'($urandom_range(0, 1)), 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
